// File: rtl/branch_predictor.sv
// Branch history table beside the IF stage: 32 two-bit saturating counters
// indexed by PC[6:2], trained by EX, with branch statistics and a debug read.
// Optional feature macro: BHT_BYPASS_EN (same-cycle write-to-lookup bypass).
module branch_predictor #(
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_IF,
  input  logic        is_branch_IF,
  output logic        predict_IF,
  input  logic        record_we,
  input  logic [4:0]  record_pc,
  input  logic        record_data,
  input  logic        record_en,
  output logic [31:0] stat_branch,
  output logic [31:0] stat_taken,
  input  logic [4:0]  dbg_addr,
  output logic [1:0]  dbg_data
);

  localparam int unsigned ENTRIES = 32;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STAT_W  = 32;

  logic [CNT_W-1:0] cnt [ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [CNT_W-1:0] rec_cur;
  logic [CNT_W-1:0] rec_nxt;
  logic             upd;
  logic             unused_pc;

  // PC bits outside the index field carry no table information (aliasing is intended)
  assign unused_pc  = ^{pc_IF[31:7], pc_IF[1:0]};
  assign lookup_idx = pc_IF[6:2];
  assign upd        = record_we & record_en;
  assign rec_cur    = cnt[record_pc];

  // Saturating step of the counter being trained this cycle
  always_comb begin
    rec_nxt = rec_cur;
    if (record_data) begin
      if (rec_cur != 2'b11) rec_nxt = rec_cur + 2'd1;
    end else begin
      if (rec_cur != 2'b00) rec_nxt = rec_cur - 2'd1;
    end
  end

  // Lookup: MSB of the counter is the taken prediction; non-branches predict 0
  always_comb begin
    predict_IF = is_branch_IF & cnt[lookup_idx][1];
`ifdef BHT_BYPASS_EN
    if (upd && (record_pc == lookup_idx)) begin
      predict_IF = is_branch_IF & rec_nxt[1];
    end
`endif
  end

  // Debug port shows stored state only, never the in-flight value
  assign dbg_data = cnt[dbg_addr];

  // Counter table: one write per cycle at the resolved branch's index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt[i] <= INIT_STATE;
      end
    end else if (upd) begin
      cnt[record_pc] <= rec_nxt;
    end
  end

  // Branch statistics; both wrap modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branch <= '0;
      stat_taken  <= '0;
    end else if (upd) begin
      stat_branch <= stat_branch + STAT_W'(1);
      stat_taken  <= stat_taken + STAT_W'(record_data);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor with an array-based reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_IF;
  logic        is_branch_IF;
  logic        predict_IF;
  logic        record_we;
  logic [4:0]  record_pc;
  logic        record_data;
  logic        record_en;
  logic [31:0] stat_branch;
  logic [31:0] stat_taken;
  logic [4:0]  dbg_addr;
  logic [1:0]  dbg_data;

  typedef struct {
    string       name;
    logic        pred;
    logic [1:0]  dbg;
    logic [31:0] sb;
    logic [31:0] st;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_cnt [32];
  logic [31:0] m_sb;
  logic [31:0] m_st;

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .pc_IF        (pc_IF),
    .is_branch_IF (is_branch_IF),
    .predict_IF   (predict_IF),
    .record_we    (record_we),
    .record_pc    (record_pc),
    .record_data  (record_data),
    .record_en    (record_en),
    .stat_branch  (stat_branch),
    .stat_taken   (stat_taken),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 1;
    m_sb = '0;
    m_st = '0;
  endfunction

  function automatic int model_next(int c, logic taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // Monitor: outputs are sampled mid-cycle and compared against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".predict"}, 32'(predict_IF), 32'(e.pred));
      chk({e.name, ".dbg"}, 32'(dbg_data), 32'(e.dbg));
      chk({e.name, ".stat_branch"}, stat_branch, e.sb);
      chk({e.name, ".stat_taken"}, stat_taken, e.st);
    end
  end

  // Drive one cycle of inputs (entered just after a rising edge), queue the
  // expected outputs, then advance the model across the next edge.
  task automatic step(input string name, input logic [31:0] pc, input logic br,
                      input logic we, input logic en, input logic [4:0] rpc,
                      input logic rdata, input logic [4:0] daddr);
    exp_t e;
    int   idx;
    int   used;
    logic upd;
    pc_IF = pc; is_branch_IF = br;
    record_we = we; record_en = en; record_pc = rpc; record_data = rdata;
    dbg_addr = daddr;
    idx  = int'(pc[6:2]);
    upd  = we & en;
    used = m_cnt[idx];
`ifdef BHT_BYPASS_EN
    if (upd && int'(rpc) == idx) used = model_next(m_cnt[idx], rdata);
`endif
    e.name = name;
    e.pred = br && (used >= 2);
    e.dbg  = 2'(m_cnt[int'(daddr)]);
    e.sb   = m_sb;
    e.st   = m_st;
    exp_q.push_back(e);
    @(posedge clk);
    if (upd) begin
      m_cnt[int'(rpc)] = model_next(m_cnt[int'(rpc)], rdata);
      m_sb = m_sb + 32'd1;
      if (rdata) m_st = m_st + 32'd1;
    end
    #1;
  endtask

  task automatic idle(input string name, input logic [31:0] pc, input logic br,
                      input logic [4:0] daddr);
    step(name, pc, br, 1'b0, 1'b0, 5'd0, 1'b0, daddr);
  endtask

  initial begin
    rst = 1'b1;
    pc_IF = '0; is_branch_IF = 1'b0;
    record_we = 1'b0; record_en = 1'b0; record_pc = '0; record_data = 1'b0;
    dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Train index 16 taken so the reset check has something to discard
    step("pre_rst_train", 32'h40, 1'b1, 1'b1, 1'b1, 5'd16, 1'b1, 5'd16);
    step("pre_rst_look",  32'h40, 1'b1, 1'b0, 1'b0, 5'd16, 1'b0, 5'd16);

    // Asynchronous reset mid-cycle
    pc_IF = 32'h0000_0040; is_branch_IF = 1'b1;
    record_we = 1'b0; record_en = 1'b0;
    #1;
    chk("pre_rst_predict", 32'(predict_IF), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_predict_async", 32'(predict_IF), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 32; a++) idle("rst_dbg", 32'h40, 1'b1, 5'(a));

    // Saturation up then down on index 5
    for (int k = 0; k < 3; k++) step("sat_up", 32'h14, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5);
    idle("sat_up_look", 32'h14, 1'b1, 5'd5);
    for (int k = 0; k < 3; k++) step("sat_dn", 32'h14, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd5);
    idle("sat_dn_look", 32'h14, 1'b1, 5'd5);
    chk("sat_model_sb", m_sb, 32'd6);

    // Gating: record_we without record_en changes nothing
    for (int k = 0; k < 4; k++) step("gate", 32'h14, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5);
    idle("gate_look", 32'h14, 1'b1, 5'd5);

    // Aliasing: 0x08 and 0x88 share index 2
    for (int k = 0; k < 2; k++) step("alias_train", 32'h08, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 5'd2);
    idle("alias_br",   32'h88, 1'b1, 5'd2);
    idle("alias_nobr", 32'h88, 1'b0, 5'd2);

    // Same-cycle collision on index 3 (counter still 01)
    step("collide", 32'h0C, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3);
    idle("collide_next", 32'h0C, 1'b1, 5'd3);

    // Statistics wrap
    @(negedge clk);
    force dut.stat_branch = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branch;
    @(posedge clk); #1;
    m_sb = 32'hFFFF_FFFF;
    step("wrap_rec", 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9);
    idle("wrap_look", 32'h0, 1'b0, 5'd9);

    // Randomized traffic, concentrated on a few indices to exercise collisions
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pc;
      logic [4:0]  rpc;
      pc  = {$urandom_range(0, 255), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) pc[6:2] = 5'($urandom_range(0, 3));
      rpc = ($urandom_range(0, 2) == 0) ? pc[6:2] : 5'($urandom_range(0, 7));
      step("rand", pc, 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) != 0), rpc, 1'($urandom), 5'($urandom));
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
